// File: rtl/tensor_axi_pkg.sv
// Shared AXI4 constants and helpers for the tensor accelerator memory path.
// Used by the read burst splitter and its burst-length calculator.
package tensor_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam int         AXI_4K_BYTES    = 4096;

    function automatic int axsize_of(input int width);
        return $clog2(width / 8);
    endfunction

    // Severity ordering DECERR > SLVERR > EXOKAY > OKAY.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        if (a == AXI_RESP_DECERR || b == AXI_RESP_DECERR) return AXI_RESP_DECERR;
        if (a == AXI_RESP_SLVERR || b == AXI_RESP_SLVERR) return AXI_RESP_SLVERR;
        if (a == AXI_RESP_EXOKAY || b == AXI_RESP_EXOKAY) return AXI_RESP_EXOKAY;
        return AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Sub-burst length: min(remaining beats, cap, beats left before the next 4 KB boundary).
// Address is assumed beat-aligned; shared with the future write splitter.
module axi_burst_len_calc
    import tensor_axi_pkg::*;
#(
    parameter int BEAT_LOG2 = 5,
    parameter int MAX_LEN   = 16
) (
    input  logic [8:0]  remaining,
    input  logic [11:0] addr_lo,
    output logic [8:0]  sub
);

    logic [12:0] to_boundary;
    logic [12:0] rem_w;
    logic [12:0] capped;
    logic [12:0] min_all;

    always_comb begin
        to_boundary = (13'(AXI_4K_BYTES) - {1'b0, addr_lo}) >> BEAT_LOG2;
        rem_w       = {4'b0, remaining};
        capped      = (rem_w < 13'(MAX_LEN)) ? rem_w : 13'(MAX_LEN);
        min_all     = (to_boundary < capped) ? to_boundary : capped;
        sub         = 9'(min_all);
    end

endmodule

// File: rtl/axi_rd_burst_splitter.sv
// AXI4 read burst splitter: one parent INCR burst split at MAX_BURST_LEN and 4 KB boundaries,
// data returned as one burst. Optional macro AXI_RD_SPLIT_STICKY_RESP_EN keeps a sticky worst rresp.
module axi_rd_burst_splitter
    import tensor_axi_pkg::*;
#(
    parameter int ADDR_W        = 40,
    parameter int DATA_W        = 256,
    parameter int ID_W          = 4,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam int AXSIZE = axsize_of(DATA_W);
    localparam logic [ADDR_W-1:0] BEAT_MASK = ~((ADDR_W'(1) << AXSIZE) - ADDR_W'(1));

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        ar_left_q, ar_left_d;
    logic [8:0]        beat_left_q, beat_left_d;
    logic [8:0]        sub;
    logic              beats_pending;
    logic              s_ar_hs, m_ar_hs, r_hs;
    logic              unused_in;

    axi_burst_len_calc #(
        .BEAT_LOG2 (AXSIZE),
        .MAX_LEN   (MAX_BURST_LEN)
    ) u_len_calc (
        .remaining (ar_left_q),
        .addr_lo   (addr_q[11:0]),
        .sub       (sub)
    );

    assign beats_pending = (beat_left_q != 9'd0);
    assign s_arready     = (state_q == S_IDLE) && !rst;
    assign m_arvalid     = (state_q == S_ISSUE);
    assign m_arid        = id_q;
    assign m_araddr      = addr_q;
    assign m_arlen       = m_arvalid ? 8'(sub - 9'd1) : 8'd0;
    assign m_arsize      = 3'(AXSIZE);
    assign m_arburst     = AXI_BURST_INCR;

    // Gating on beat_left keeps stray beats from leaking past the parent's end.
    assign s_rvalid = m_rvalid && beats_pending;
    assign m_rready = s_rready && beats_pending;
    assign s_rid    = id_q;
    assign s_rdata  = m_rdata;
    assign s_rlast  = (beat_left_q == 9'd1);

    assign s_ar_hs = s_arvalid && s_arready;
    assign m_ar_hs = m_arvalid && m_arready;
    assign r_hs    = s_rvalid && s_rready;

    assign unused_in = ^{m_rid, m_rlast};

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        ar_left_d   = ar_left_q;
        beat_left_d = beat_left_q;
        if (r_hs) beat_left_d = beat_left_q - 9'd1;
        case (state_q)
            S_IDLE: begin
                if (s_ar_hs) begin
                    id_d        = s_arid;
                    addr_d      = s_araddr & BEAT_MASK;
                    ar_left_d   = {1'b0, s_arlen} + 9'd1;
                    beat_left_d = {1'b0, s_arlen} + 9'd1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_ar_hs) begin
                    addr_d    = addr_q + (ADDR_W'(sub) << AXSIZE);
                    ar_left_d = ar_left_q - sub;
                    // Skip DRAIN when the last beat lands with the last AR.
                    if (ar_left_d == 9'd0) state_d = (beat_left_d == 9'd0) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (beat_left_d == 9'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            ar_left_q   <= '0;
            beat_left_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            ar_left_q   <= ar_left_d;
            beat_left_q <= beat_left_d;
        end
    end

`ifdef AXI_RD_SPLIT_STICKY_RESP_EN
    logic [1:0] resp_q, resp_d;

    always_comb begin
        resp_d = resp_q;
        if (s_ar_hs)   resp_d = AXI_RESP_OKAY;
        else if (r_hs) resp_d = resp_worst(resp_q, m_rresp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) resp_q <= AXI_RESP_OKAY;
        else     resp_q <= resp_d;
    end

    assign s_rresp = resp_worst(resp_q, m_rresp);
`else
    assign s_rresp = m_rresp;
`endif

endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// Directed bench for axi_rd_burst_splitter: reactive memory model plus AR/R scoreboards.
module tb_axi_rd_burst_splitter;
    import tensor_axi_pkg::*;

    localparam int ADDR_W = 40;
    localparam int DATA_W = 256;
    localparam int ID_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ID_W-1:0]   s_arid;
    logic [ADDR_W-1:0] s_araddr;
    logic [7:0]        s_arlen;
    logic              s_arvalid;
    logic              s_arready;
    logic [ID_W-1:0]   s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready;
    logic [ID_W-1:0]   m_arid;
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready;
    logic [ID_W-1:0]   m_rid;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;

    always #5 clk = ~clk;

    axi_rd_burst_splitter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_BURST_LEN(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [DATA_W-1:0] data; logic [1:0] resp; logic last; } r_t;

    ar_t exp_ar_q[$];
    r_t  exp_r_q[$];
    ar_t slv_q[$];

    int n_assert = 0, n_fail = 0;
    int slv_beat = 0, slv_cnt = 0, err_beat = 0, ar_hold = 0;
    int r_cnt = 0, mrlast_cnt = 0;
    bit rready_toggle = 0, chk_arrdy_next = 0;
    bit slv_ar_hs, slv_r_hs;
    ar_t slv_ar;
    logic [ID_W-1:0] cur_id = '0;
    bit stall_v = 0;
    logic [ADDR_W-1:0] stall_addr;
    logic [7:0] stall_len;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = a[31:0] ^ 32'hA5A5_0000;
        return {8{w}};
    endfunction

    function automatic logic [1:0] resp_exp(input int k);
`ifdef AXI_RD_SPLIT_STICKY_RESP_EN
        return (err_beat != 0 && k >= err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`else
        return (err_beat != 0 && k == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`endif
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: accepts sub-bursts, returns beats in order with m_rlast per sub-burst.
    initial begin
        m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
        m_rlast = 1'b0; m_rid = '0; s_rready = 1'b1;
        forever begin
            @(negedge clk);
            slv_ar_hs = m_arvalid && m_arready;
            slv_r_hs  = m_rvalid && m_rready;
            slv_ar.addr = m_araddr;
            slv_ar.len  = m_arlen;
            @(posedge clk); #1;
            if (rst) begin
                slv_q.delete(); slv_beat = 0; m_rvalid = 1'b0; m_rlast = 1'b0;
                continue;
            end
            if (slv_ar_hs) slv_q.push_back(slv_ar);
            if (slv_r_hs) begin
                slv_cnt++;
                if (slv_beat == int'(slv_q[0].len)) begin
                    slv_beat = 0;
                    void'(slv_q.pop_front());
                end else slv_beat++;
            end
            if (ar_hold > 0) begin
                m_arready = 1'b0;
                if (m_arvalid) ar_hold--;
            end else m_arready = 1'b1;
            s_rready = rready_toggle ? !s_rready : 1'b1;
            if (slv_q.size() > 0) begin
                m_rvalid = 1'b1;
                m_rdata  = pat(slv_q[0].addr + ADDR_W'(slv_beat * 32));
                m_rlast  = (slv_beat == int'(slv_q[0].len));
                m_rresp  = (err_beat != 0 && slv_cnt + 1 == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else begin
                m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = AXI_RESP_OKAY;
            end
        end
    end

    // Scoreboard monitor on the falling edge.
    initial begin
        ar_t ea;
        r_t  er;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk_arrdy_next = 0; stall_v = 0;
                continue;
            end
            if (chk_arrdy_next) begin
                chk("arready_after_last", s_arready, 1);
                chk_arrdy_next = 0;
            end else if (exp_r_q.size() > 0) chk("arready_busy", s_arready, 0);
            if (stall_v) begin
                chk("ar_stall_valid", m_arvalid, 1);
                chk("ar_stall_addr", m_araddr, stall_addr);
                chk("ar_stall_len", m_arlen, stall_len);
            end
            stall_v = m_arvalid && !m_arready;
            stall_addr = m_araddr;
            stall_len = m_arlen;
            if (m_arvalid && m_arready) begin
                if (exp_ar_q.size() == 0) chk("ar_unexpected", exp_ar_q.size(), 1);
                else begin
                    ea = exp_ar_q.pop_front();
                    chk("m_araddr", m_araddr, ea.addr);
                    chk("m_arlen", m_arlen, ea.len);
                    chk("m_arid", m_arid, cur_id);
                    chk("m_arsize", m_arsize, 5);
                    chk("m_arburst", m_arburst, 1);
                end
            end
            if (m_rvalid && m_rready && m_rlast) mrlast_cnt++;
            if (s_rvalid && s_rready) begin
                r_cnt++;
                if (exp_r_q.size() == 0) chk("r_unexpected", exp_r_q.size(), 1);
                else begin
                    er = exp_r_q.pop_front();
                    chk("s_rdata", s_rdata, er.data);
                    chk("s_rresp", s_rresp, er.resp);
                    chk("s_rlast", s_rlast, er.last);
                    chk("s_rid", s_rid, cur_id);
                    if (er.last) chk_arrdy_next = 1;
                end
            end
        end
    end

    task automatic push_ar(input logic [ADDR_W-1:0] a, input logic [7:0] len);
        ar_t e;
        e.addr = a; e.len = len;
        exp_ar_q.push_back(e);
    endtask

    task automatic send_parent(input logic [ADDR_W-1:0] a, input int len, input logic [ID_W-1:0] id);
        bit acc;
        r_t e;
        acc = 0;
        cur_id = id;
        @(posedge clk); #1;
        s_arid = id; s_araddr = a; s_arlen = 8'(len); s_arvalid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (s_arready) acc = 1;
        end
        chk("s_ar_accept", acc, 1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            e.data = pat(a + ADDR_W'(i * 32));
            e.resp = resp_exp(i + 1);
            e.last = (i == len);
            exp_r_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            if (exp_r_q.size() == 0 && exp_ar_q.size() == 0 && !chk_arrdy_next) done = 1;
        end
        chk(tag, done, 1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_s_arready"}, s_arready, 0);
        chk({pfx, "_m_arvalid"}, m_arvalid, 0);
        chk({pfx, "_m_rready"}, m_rready, 0);
        chk({pfx, "_s_rvalid"}, s_rvalid, 0);
        chk({pfx, "_s_rlast"}, s_rlast, 0);
        chk({pfx, "_s_rid"}, s_rid, 0);
        chk({pfx, "_m_araddr"}, m_araddr, 0);
        chk({pfx, "_m_arlen"}, m_arlen, 0);
    endtask

    initial begin
        bit hit;
        s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // Single sub-burst.
        push_ar(40'h1000, 8'd15);
        send_parent(40'h1000, 15, 4'd1);
        wait_done("t1_done", 200);

        // Split by length cap.
        mrlast_cnt = 0;
        push_ar(40'h000, 8'd15); push_ar(40'h200, 8'd15);
        push_ar(40'h400, 8'd15); push_ar(40'h600, 8'd15);
        send_parent(40'h0, 63, 4'd2);
        wait_done("t2_done", 400);
        chk("t2_m_rlast_count", mrlast_cnt, 4);

        // Split at a 4 KB crossing.
        mrlast_cnt = 0;
        push_ar(40'h0FC0, 8'd1); push_ar(40'h1000, 8'd5);
        send_parent(40'h0FC0, 7, 4'd3);
        wait_done("t3_done", 200);
        chk("t3_m_rlast_count", mrlast_cnt, 2);

        // AR stall plus R backpressure.
        ar_hold = 5; rready_toggle = 1;
        push_ar(40'h5000, 8'd15); push_ar(40'h5200, 8'd15);
        send_parent(40'h5000, 31, 4'd4);
        wait_done("t4_done", 400);
        rready_toggle = 0;
        chk("t4_hold_consumed", ar_hold, 0);

        // Error response on beat 3 of 8.
        err_beat = 3; slv_cnt = 0;
        push_ar(40'h3000, 8'd7);
        send_parent(40'h3000, 7, 4'd6);
        wait_done("t6_done", 200);
        err_beat = 0;

        // Reset mid-burst, then a clean parent.
        r_cnt = 0;
        push_ar(40'h000, 8'd15); push_ar(40'h200, 8'd15);
        push_ar(40'h400, 8'd15); push_ar(40'h600, 8'd15);
        send_parent(40'h0, 63, 4'd5);
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk); #1;
            if (r_cnt >= 10) hit = 1;
        end
        chk("t5_ten_beats", hit, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t5_rst");
        exp_r_q.delete(); exp_ar_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_ar(40'h2000, 8'd3);
        send_parent(40'h2000, 3, 4'd7);
        wait_done("t5_after_done", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_burst_splitter.md
Name: axi_rd_burst_splitter

Overview:
- Sits directly downstream of the accelerator top's AXI4 master read channel (AR/R), between the accelerator and the DDR/HBM controller.
- Splits each incoming INCR read burst into sub-bursts that never exceed MAX_BURST_LEN beats and never cross a 4 KB address boundary.
- Re-assembles the returned data stream so the accelerator sees exactly one burst with a single rlast.
- Handles one parent burst at a time; read data is a combinational pass-through.

Parameters:
ADDR_W, 40, AXI address width
DATA_W, 256, AXI data width; beat bytes B = DATA_W/8
ID_W, 4, AXI ID width
MAX_BURST_LEN, 16, maximum beats per issued sub-burst (1..256)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
s_arid  input  ID_W  parent burst ID
s_araddr  input  ADDR_W  parent start address, beat-aligned
s_arlen  input  8  parent beats minus 1
s_arvalid  input  1  parent request valid
s_arready  output  1  parent accepted
s_rid  output  ID_W  latched parent ID
s_rdata  output  DATA_W  read data
s_rresp  output  2  read response
s_rlast  output  1  last beat of parent
s_rvalid  output  1  data valid
s_rready  input  1  data accepted
m_arid  output  ID_W  sub-burst ID (= parent ID)
m_araddr  output  ADDR_W  sub-burst address
m_arlen  output  8  sub-burst beats minus 1
m_arsize  output  3  constant log2(B)
m_arburst  output  2  constant INCR (2'b01)
m_arvalid  output  1  sub-burst request valid
m_arready  input  1  sub-burst accepted
m_rid  input  ID_W  ignored
m_rdata  input  DATA_W  read data
m_rresp  input  2  read response
m_rlast  input  1  last beat of sub-burst
m_rvalid  input  1  data valid
m_rready  output  1  data accepted

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, all counters 0. Outputs while rst=1: s_arready=0, m_arvalid=0, m_rready=0, s_rvalid=0, s_rlast=0, s_rid=0, m_araddr=0, m_arlen=0. The same applies when reset hits mid-burst; no recovery of the in-flight burst is required.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - s_arready=1.
  - On s_arvalid&&s_arready: latch id; latch addr with low log2(B) bits zeroed; set ar_left = beat_left = s_arlen+1 (9-bit); go to ISSUE.
- ISSUE:
  - m_arvalid=1, registered fields, valid from the cycle after parent acceptance.
  - sub = min(ar_left, MAX_BURST_LEN, (4096 - addr[11:0])/B). m_arlen = sub-1.
  - On m_arready: addr += sub*B; ar_left -= sub. If ar_left becomes 0, go to DRAIN; otherwise issue the next sub-burst the following cycle.
  - m_arvalid/m_araddr/m_arlen are held stable while m_arready=0.
- DRAIN: wait until beat_left==0, then go to IDLE.
- R path (ISSUE and DRAIN):
  - s_rvalid = m_rvalid && (beat_left!=0); m_rready = s_rready && (beat_left!=0).
  - s_rdata = m_rdata; s_rresp = m_rresp; s_rid = latched id.
  - s_rlast = (beat_left==1). m_rlast is used only by the optional check.
  - Each s_rvalid&&s_rready handshake decrements beat_left.
- Data may return while sub-bursts are still being issued; a beat and an AR handshake in the same cycle are both processed.
- s_arready returns to 1 the cycle after the final beat handshake.
- Beats arriving when beat_left==0 are not accepted (m_rready=0).
- Parent bursts longer than the boundary limit are split at every 4 KB crossing.

Optional Feature:
- Macro: AXI_RD_SPLIT_STICKY_RESP_EN.
- Defined: a sticky 2-bit worst response is kept per parent, ordered DECERR>SLVERR>OKAY. s_rresp = max(sticky, m_rresp) on each beat. The sticky register clears on parent acceptance.
- Undefined: s_rresp passes m_rresp through per beat.

Decomposition:
- Shared package tensor_axi_pkg:
  - AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR
  - AXI_4K_BYTES=4096
  - function axsize_of(width)
- Sub-module axi_burst_len_calc: combinational min of remaining beats, cap and beats-to-boundary, returning sub. It will be reused by a future write splitter.

Test Plan (DATA_W=256, B=32, MAX_BURST_LEN=16):
1. araddr=0x1000, arlen=15 -> one m_ar {0x1000, len 15}; 16 beats forwarded; s_rlast only on beat 16; s_arready high again the cycle after.
2. araddr=0x0, arlen=63 -> m_ar at 0x000/0x200/0x400/0x600, each len 15; m_rlast seen 4 times; s_rlast only on beat 64.
3. araddr=0x0FC0, arlen=7 -> m_ar {0x0FC0, len 1} then {0x1000, len 5}; 8 beats, single s_rlast.
4. m_arready held low 5 cycles, s_rready toggled every cycle -> m_ar fields stable while stalled; no beat lost or duplicated; s_arready=0 until the final beat.
5. rst pulsed after 10 of 64 beats -> all outputs at reset values immediately; a following parent {0x2000, len 3} completes normally.
6. With the macro defined, SLVERR on beat 3 of 8 -> s_rresp=SLVERR on beats 3..8. Without the macro, only beat 3 shows SLVERR.
